// File: rtl/traffic_lights_pkg.sv
// Shared types and helpers for the traffic_lights controller and its
// command-side generator: command codes, host request codes, and the
// mapping from (request, step index) to the command and payload emitted.
package traffic_lights_pkg;

  localparam int CMD_W  = 3;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    CMD_ON           = 3'd0,
    CMD_OFF          = 3'd1,
    CMD_NOTRANSITION = 3'd2,
    CMD_SET_GREEN    = 3'd3,
    CMD_SET_RED      = 3'd4,
    CMD_SET_YELLOW   = 3'd5
  } cmd_type_t;

  typedef enum logic [1:0] {
    REQ_PROGRAM = 2'd0,
    REQ_ON      = 2'd1,
    REQ_OFF     = 2'd2,
    REQ_BLINK   = 2'd3
  } req_type_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } gen_state_t;

  // Command emitted at step idx of a request's expansion.
  function automatic cmd_type_t cmd_for_step(input req_type_t t, input logic [2:0] idx);
    cmd_type_t c;
    c = CMD_ON;
    case (t)
      REQ_PROGRAM: begin
        case (idx)
          3'd0:    c = CMD_NOTRANSITION;
          3'd1:    c = CMD_SET_GREEN;
          3'd2:    c = CMD_SET_RED;
          3'd3:    c = CMD_SET_YELLOW;
          default: c = CMD_ON;
        endcase
      end
      REQ_ON:    c = CMD_ON;
      REQ_OFF:   c = CMD_OFF;
      REQ_BLINK: c = CMD_NOTRANSITION;
      default:   c = CMD_ON;
    endcase
    return c;
  endfunction

  // Payload for step idx: only the SET_* steps of PROGRAM carry a time.
  function automatic logic [15:0] data_for_step(input req_type_t t, input logic [2:0] idx,
                                                input logic [15:0] green,
                                                input logic [15:0] red,
                                                input logic [15:0] yellow);
    logic [15:0] d;
    d = 16'd0;
    if (t == REQ_PROGRAM) begin
      case (idx)
        3'd1:    d = green;
        3'd2:    d = red;
        3'd3:    d = yellow;
        default: d = 16'd0;
      endcase
    end else begin
      d = 16'd0;
    end
    return d;
  endfunction

  // Index of the final step of a request's expansion.
  function automatic logic [2:0] last_step(input req_type_t t);
    logic [2:0] n;
    if (t == REQ_PROGRAM) begin
      n = 3'd4;
    end else begin
      n = 3'd0;
    end
    return n;
  endfunction

endpackage

// File: rtl/traffic_lights_cmd_gen.sv
// Command-side master for traffic_lights: accepts host requests over a
// valid/ready handshake and expands each into a spaced sequence of
// one-cycle command strobes. Every output comes straight from a flop.
module traffic_lights_cmd_gen #(
  parameter int unsigned CMD_GAP = 2
) (
  input  logic        clk_i,
  input  logic        srst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_type_i,
  input  logic [15:0] req_green_ms_i,
  input  logic [15:0] req_red_ms_i,
  input  logic [15:0] req_yellow_ms_i,
  output logic [2:0]  cmd_type_o,
  output logic        cmd_valid_o,
  output logic [15:0] cmd_data_o,
  output logic        busy_o,
  output logic        err_o
);

  import traffic_lights_pkg::*;

  // Gap counter runs 0..CMD_GAP-1; with no gap the GAP state is unreachable.
  localparam logic       GAP_EN   = (CMD_GAP != 0);
  localparam logic [3:0] GAP_LAST = (CMD_GAP == 0) ? 4'd0 : 4'(CMD_GAP - 1);

  gen_state_t  state_r, state_s;
  logic [2:0]  idx_r, idx_s;
  logic [3:0]  gap_r, gap_s;
  req_type_t   req_type_r, req_type_s;
  logic [15:0] green_r, green_s;
  logic [15:0] red_r, red_s;
  logic [15:0] yellow_r, yellow_s;
  cmd_type_t   cmd_type_r, cmd_type_s;
  logic        cmd_valid_r, cmd_valid_s;
  logic [15:0] cmd_data_r, cmd_data_s;
  logic        ready_r, ready_s;
  logic        busy_r, busy_s;
  logic        err_r, err_s;

  req_type_t   in_type_s;
  logic        accept_s;
  logic        reject_s;
  logic        seq_done_s;
  logic [2:0]  idx_next_s;

  assign in_type_s  = req_type_t'(req_type_i);
  assign accept_s   = req_valid_i && ready_r;
  assign reject_s   = (in_type_s == REQ_PROGRAM) &&
                      ((req_green_ms_i == 16'd0) || (req_red_ms_i == 16'd0) ||
                       (req_yellow_ms_i == 16'd0));
  assign seq_done_s = (idx_r == last_step(req_type_r));
  assign idx_next_s = idx_r + 3'd1;

  // Next-state and next-output computation; output flops take these values.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    gap_s       = gap_r;
    req_type_s  = req_type_r;
    green_s     = green_r;
    red_s       = red_r;
    yellow_s    = yellow_r;
    cmd_type_s  = CMD_ON;
    cmd_valid_s = 1'b0;
    cmd_data_s  = 16'd0;
    ready_s     = 1'b0;
    busy_s      = 1'b0;
    err_s       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          req_type_s = in_type_s;
          green_s    = req_green_ms_i;
          red_s      = req_red_ms_i;
          yellow_s   = req_yellow_ms_i;
          idx_s      = 3'd0;
          gap_s      = 4'd0;
          if (reject_s) begin
            err_s   = 1'b1;
            ready_s = 1'b1;
            state_s = ST_IDLE;
          end else begin
            state_s     = ST_SEND;
            cmd_valid_s = 1'b1;
            cmd_type_s  = cmd_for_step(in_type_s, 3'd0);
            cmd_data_s  = data_for_step(in_type_s, 3'd0, req_green_ms_i,
                                        req_red_ms_i, req_yellow_ms_i);
            busy_s      = 1'b1;
          end
        end else begin
          ready_s = 1'b1;
        end
      end

      ST_SEND: begin
        if (GAP_EN) begin
          state_s = ST_GAP;
          gap_s   = 4'd0;
          busy_s  = 1'b1;
        end else if (seq_done_s) begin
          state_s = ST_IDLE;
          ready_s = 1'b1;
        end else begin
          state_s     = ST_SEND;
          idx_s       = idx_next_s;
          cmd_valid_s = 1'b1;
          cmd_type_s  = cmd_for_step(req_type_r, idx_next_s);
          cmd_data_s  = data_for_step(req_type_r, idx_next_s, green_r, red_r, yellow_r);
          busy_s      = 1'b1;
        end
      end

      ST_GAP: begin
        if (gap_r != GAP_LAST) begin
          gap_s  = gap_r + 4'd1;
          busy_s = 1'b1;
        end else if (seq_done_s) begin
          state_s = ST_IDLE;
          gap_s   = 4'd0;
          ready_s = 1'b1;
        end else begin
          state_s     = ST_SEND;
          gap_s       = 4'd0;
          idx_s       = idx_next_s;
          cmd_valid_s = 1'b1;
          cmd_type_s  = cmd_for_step(req_type_r, idx_next_s);
          cmd_data_s  = data_for_step(req_type_r, idx_next_s, green_r, red_r, yellow_r);
          busy_s      = 1'b1;
        end
      end

      default: begin
        state_s = ST_IDLE;
        idx_s   = 3'd0;
        gap_s   = 4'd0;
      end
    endcase
  end

  // State, latched request and registered outputs; reset aborts any sequence.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_r     <= ST_IDLE;
      idx_r       <= 3'd0;
      gap_r       <= 4'd0;
      req_type_r  <= REQ_PROGRAM;
      green_r     <= 16'd0;
      red_r       <= 16'd0;
      yellow_r    <= 16'd0;
      cmd_type_r  <= CMD_ON;
      cmd_valid_r <= 1'b0;
      cmd_data_r  <= 16'd0;
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      gap_r       <= gap_s;
      req_type_r  <= req_type_s;
      green_r     <= green_s;
      red_r       <= red_s;
      yellow_r    <= yellow_s;
      cmd_type_r  <= cmd_type_s;
      cmd_valid_r <= cmd_valid_s;
      cmd_data_r  <= cmd_data_s;
      ready_r     <= ready_s;
      busy_r      <= busy_s;
      err_r       <= err_s;
    end
  end

  assign req_ready_o = ready_r;
  assign cmd_type_o  = cmd_type_r;
  assign cmd_valid_o = cmd_valid_r;
  assign cmd_data_o  = cmd_data_r;
  assign busy_o      = busy_r;
  assign err_o       = err_r;

endmodule
